// File: rtl/pipe_stage_reg_pkg.sv
// misc_v_pipe_pkg: shared types and constants for the MISC-V inter-stage
// pipeline registers.
//   pipe_state_e : occupancy state of a pipe_stage_reg (EMPTY/FULL/SKID)
//   EXMEM_*      : bit positions of the EX/MEM control bundle
//   CTRL_W_EXMEM : width of the EX/MEM control bundle
package misc_v_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held, outputs show a bubble
        FULL  = 2'd1,   // main register holds the head entry
        SKID  = 2'd2    // main and skid both hold entries
    } pipe_state_e;

    localparam int CTRL_W_EXMEM   = 8;
    localparam int EXMEM_REGWRITE = 0;
    localparam int EXMEM_ALUSRC   = 1;
    localparam int EXMEM_ALUOP_LO = 2;
    localparam int EXMEM_ALUOP_HI = 4;
    localparam int EXMEM_MEMWRITE = 5;
    localparam int EXMEM_MEMREAD  = 6;
    localparam int EXMEM_REGSTORE = 7;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter used for performance debug.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high clear
//   inc_i : count one event this cycle
//   cnt_o : current count, sticks at all-ones
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised valid/ready pipeline stage register carrying a
// control bundle plus NDATA data words, with synchronous flush and a
// saturating back-pressure counter.
// Configuration macro PIPE_STAGE_SKID_EN:
//   defined   : 2-entry (main + skid) storage, in_ready is registered.
//   undefined : single entry, in_ready = !out_valid || out_ready.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   flush                 : discard held entries and this cycle's input
//   in_valid/in_ready     : upstream handshake
//   in_ctrl/in_data       : upstream control bundle / data words
//   out_valid/out_ready   : downstream handshake
//   out_ctrl/out_data     : held control (zero on a bubble) / data words
//   stall_cnt             : cycles with out_valid && !out_ready (saturating)
module pipe_stage_reg
    import misc_v_pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 16,
    parameter int NDATA  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [NDATA*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [NDATA*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int DW = NDATA * DATA_W;

    pipe_state_e       state_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DW-1:0]     main_data_q;
    logic              accept;
    logic              fire;

    assign out_valid = (state_q != EMPTY);
    assign fire      = out_valid && out_ready;
    // A flush cycle never accepts, even if upstream sees in_ready high.
    assign accept    = in_valid && in_ready && !flush;

`ifdef PIPE_STAGE_SKID_EN
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DW-1:0]     skid_data_q;

    // Registered: upstream never sees a path from out_ready.
    assign in_ready = (state_q != SKID);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else if (flush) begin
            // Data registers keep their contents; only occupancy is dropped.
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q     <= FULL;
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                    end
                end
                FULL: begin
                    if (fire && accept) begin
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                    end else if (fire) begin
                        state_q <= EMPTY;
                    end else if (accept) begin
                        state_q     <= SKID;
                        skid_ctrl_q <= in_ctrl;
                        skid_data_q <= in_data;
                    end
                end
                SKID: begin
                    if (fire) begin
                        state_q     <= FULL;
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
`else
    // Single entry: a slot frees up in the same cycle the head fires.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q     <= FULL;
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                    end
                end
                FULL: begin
                    // accept implies fire here since in_ready needs out_ready.
                    if (accept) begin
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                    end else if (fire) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
`endif

    // Bubbles must not assert RegWrite/MemWrite/MemRead downstream.
    assign out_ctrl = out_valid ? main_ctrl_q : '0;
    assign out_data = main_data_q;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (out_valid && !out_ready),
        .cnt_o (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed phases followed by random
// traffic, checked by a scoreboard queue of accepted entries.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 16;
    localparam int NDATA  = 3;
    localparam int CNT_W  = 4;
    localparam int DW     = NDATA * DATA_W;
    localparam int SMAX   = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID_MODE = 1'b1;
`else
    localparam bit SKID_MODE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DW-1:0]     in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DW-1:0]     out_data;
    logic [CNT_W-1:0]  stall_cnt;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DW-1:0]     d;
    } ent_t;

    ent_t sb[$];
    int   stall_m = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    pipe_stage_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .NDATA  (NDATA),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // Monitor: samples just before each rising edge, compares the DUT
    // against the queue model, then advances the model across the edge.
    initial begin
        bit   ev, er, fr, acc;
        ent_t e;
        forever begin
            @(negedge clk);
            #4;
            ev = (sb.size() > 0);
            er = SKID_MODE ? (sb.size() < 2) : (!ev || out_ready);
            if (!reset || sb.size() > 0 || stall_m > 0 || n_chk > 0) begin
                if (n_chk > 0 || !reset) begin
                    chk("out_valid", 64'(out_valid), 64'(ev));
                    chk("in_ready", 64'(in_ready), 64'(er));
                    chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
                    if (!ev) chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
                end
            end
            fr  = ev && out_ready;
            acc = in_valid && er;
            if (reset) begin
                sb.delete();
                stall_m = 0;
            end else begin
                if (ev && !out_ready && stall_m < SMAX) stall_m++;
                if (flush) begin
                    sb.delete();
                end else begin
                    if (fr) begin
                        e = sb.pop_front();
                        chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
                        chk("out_data", 64'(out_data), 64'(e.d));
                    end
                    if (acc) sb.push_back({in_ctrl, in_data});
                end
            end
        end
    end

    // Holds the current input until the DUT takes it (bounded).
    task automatic hold_until_taken();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #4;
            got = in_ready;
            @(negedge clk);
            if (got) break;
        end
        in_valid = 1'b0;
        chk("accept_timeout", 64'(got), 64'd1);
    endtask

    initial begin
        // Reset with junk presented on the input.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 8'hFF;
        in_data  = rnd_data();
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #4;
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_stall", 64'(stall_cnt), 64'd0);

        // Streaming, ALUResult 1..4 back to back.
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_ctrl  = 8'($urandom());
            in_data  = {32'($urandom()), 16'(k)};
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Back-pressure with three entries offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h41;
        in_data   = {32'h0, 16'hAAAA};
        @(negedge clk);
        in_ctrl = 8'h42;
        in_data = {32'h0, 16'hBBBB};
        @(negedge clk);
        in_ctrl = 8'h43;
        in_data = {32'h0, 16'hCCCC};
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        hold_until_taken();
        repeat (5) @(negedge clk);

        // Flush with two entries held and a new one presented.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h61;
        in_data   = rnd_data();
        @(negedge clk);
        in_ctrl = 8'h62;
        in_data = rnd_data();
        @(negedge clk);
        flush   = 1'b1;
        in_ctrl = 8'h63;
        in_data = rnd_data();
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #4;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        repeat (5) @(negedge clk);

        // Stall counter saturation.
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h21;
        in_data   = rnd_data();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        #4;
        chk("stall_sat", 64'(stall_cnt), 64'(SMAX));
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_ctrl   = 8'($urandom());
            in_data   = rnd_data();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #4;
        chk("drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the MISC-V core, the generalised replacement for the hand-written inter-stage latches (EX/MEM first, then ID/EX and MEM/WB). Carries a control bundle and NDATA data words of DATA_W bits between stages with a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, and a synchronous flush that inserts a bubble. A saturating stall counter exposes back-pressure cycles for performance debug.

## Interface
- CTRL_W, 8, control bundle width (EX/MEM: RegWrite, ALUSrc, ALUOP[2:0], MemWrite, MemRead, RegStore)
- DATA_W, 16, width of one data word
- NDATA, 3, number of data words (EX/MEM: ALUResult, 3rdArg, Rd)
- CNT_W, 16, stall counter width
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous kill of all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  NDATA*DATA_W  upstream data words, word k at [k*DATA_W +: DATA_W]
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control bundle, forced to 0 when out_valid=0
- out_data  out  NDATA*DATA_W  data words
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- Accept: in_valid && in_ready at a rising edge (not in a flush cycle). Fire: out_valid && out_ready.
- Storage: main register (drives outputs) and skid register. States EMPTY, FULL, SKID.
- EMPTY: in_ready=1. Accept -> FULL, main <= input.
- FULL: in_ready=1. Fire & accept -> FULL, main <= input. Fire & no accept -> EMPTY. Accept & no fire -> SKID, skid <= input. Neither -> FULL, hold.
- SKID: in_ready=0. Fire -> FULL, main <= skid. Else hold.
- out_valid = (state != EMPTY). in_ready = (state != SKID), derived from registered state only (no combinational path out_ready -> in_ready).
- out_ctrl = out_valid ? main_ctrl : 0, so a bubble never asserts RegWrite/MemWrite/MemRead downstream.
- Flush: next state EMPTY; entries in main, skid and any input presented that cycle are discarded. out_data holds its last value (don't-care while invalid). Flush does not clear stall_cnt.
- Reset: state EMPTY, main and skid cleared to 0, stall_cnt = 0. Reset dominates flush.
- stall_cnt increments by 1 each cycle out_valid && !out_ready; saturates at 2^CNT_W-1, no wrap.
- Ordering: entries leave in acceptance order; no entry duplicated or dropped except by flush/reset.

## Timing
- Latency 1 cycle: accept at edge N -> out_valid at N (visible after edge N), fireable at edge N+1.
- Throughput 1 entry/cycle with out_ready held high.
- Back-pressure: at most one further entry accepted after out_ready drops (into skid); in_ready deasserts the cycle after.
- After reset deasserts: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0.
- flush and out_ready in same cycle: flush wins; the fire is counted as occurring for the upstream driver only if it also observed it, so downstream must not act on an entry in a flush cycle (pipeline controller guarantees this).

## Configuration
- PIPE_STAGE_SKID_EN defined: behaviour above, registered in_ready, 2 entries.
- Undefined: no skid register, states EMPTY/FULL only; in_ready = !out_valid || out_ready (combinational); FULL with accept & no fire cannot occur. Latency and flush/reset behaviour unchanged.

## Structure
- Package misc_v_pipe_pkg: state enum (EMPTY, FULL, SKID), EX/MEM control bit positions (REGWRITE=0, ALUSRC=1, ALUOP=4:2, MEMWRITE=5, MEMREAD=6, REGSTORE=7), CTRL_W_EXMEM=8.
- One sub-module: pipe_sat_counter (CNT_W, inc, synchronous reset, saturating) for stall_cnt.

## Test plan
- Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0x00, out_data=0, stall_cnt=0, in_ready=1.
- Streaming: out_ready=1, send 4 entries ALUResult 0x0001..0x0004 back to back -> appear in order one cycle later, one per cycle, stall_cnt stays 0.
- Back-pressure: out_ready=0 while sending 0xAAAA, 0xBBBB, 0xCCCC -> 0xAAAA held, 0xBBBB in skid, in_ready=0 next cycle, 0xCCCC not accepted; release -> 0xAAAA, 0xBBBB, 0xCCCC in order; stall_cnt equals stalled cycles.
- Flush in SKID: two entries held, pulse flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0x00, in_ready=1, no entry later emerges.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with valid held -> stall_cnt reaches 0xF and stays.
- Without PIPE_STAGE_SKID_EN: out_ready=0 with entry held -> in_ready=0 same cycle; raise out_ready -> in_ready=1 same cycle, new entry accepted on that edge.
